// File: rtl/locked_adder_key_tester.sv
// Scores one candidate key against a key-locked 16-bit adder: drives an LFSR
// pattern stream, compares each 17-bit response to the true sum, reports counts.
module locked_adder_key_tester #(
    parameter int          NUM_PATTERNS = 256,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
    parameter int          CW           = $clog2(NUM_PATTERNS + 1),
    parameter int          BW           = $clog2(17 * NUM_PATTERNS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [31:0]   key_i,
    output logic [31:0]   key_o,
    output logic [15:0]   add1_o,
    output logic [15:0]   add2_o,
    input  logic [16:0]   locked_result_i,
    output logic          busy_o,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [CW-1:0] err_count_o,
    output logic [BW-1:0] bitflip_o,
    output logic [31:0]   first_fail_o,
    output logic          pass_o
);

    localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [15:0] LAST = 16'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   lfsr;
    logic [31:0]   key;
    logic [15:0]   cnt;
    logic [CW-1:0] err_cnt;
    logic [BW-1:0] bf_cnt;
    logic [31:0]   first_fail;
    logic          fail_seen;
    logic          pass;

    logic [16:0]   golden;
    logic [16:0]   diff;
    logic          miss;
    logic [4:0]    flips;
    logic [CW-1:0] err_nxt;
    logic          last;

    function automatic logic [4:0] popcount17(input logic [16:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 17; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    // The operands are the LFSR halves; the LFSR is not stepped on the last
    // compare, so the final pattern stays on the operands while idle.
    assign golden  = {1'b0, lfsr[31:16]} + {1'b0, lfsr[15:0]};
    assign diff    = locked_result_i ^ golden;
    assign miss    = |diff;
    assign flips   = popcount17(diff);
    assign err_nxt = err_cnt + CW'(miss);
    assign last    = (cnt == 16'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)     state_nxt = RUN;
            RUN:     if (last)        state_nxt = REPORT;
            REPORT:  if (res_ready_i) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= 32'd0;
            key        <= 32'd0;
            cnt        <= 16'd0;
            err_cnt    <= '0;
            bf_cnt     <= '0;
            first_fail <= 32'd0;
            fail_seen  <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        key        <= key_i;
                        lfsr       <= SEED;
                        cnt        <= LAST;
                        err_cnt    <= '0;
                        bf_cnt     <= '0;
                        first_fail <= 32'd0;
                        fail_seen  <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                RUN: begin
                    err_cnt <= err_nxt;
                    bf_cnt  <= bf_cnt + BW'(flips);
                    if (miss && !fail_seen) begin
                        first_fail <= lfsr;
                        fail_seen  <= 1'b1;
                    end
                    if (last) begin
                        pass <= (err_nxt == '0);
                    end else begin
                        cnt  <= cnt - 16'd1;
                        lfsr <= lfsr_next(lfsr);
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_o        = key;
    assign add1_o       = lfsr[31:16];
    assign add2_o       = lfsr[15:0];
    assign busy_o       = (state != IDLE);
    assign res_valid_o  = (state == REPORT);
    assign err_count_o  = err_cnt;
    assign bitflip_o    = bf_cnt;
    assign first_fail_o = first_fail;
    assign pass_o       = pass;

endmodule

// File: tb/tb_locked_adder_key_tester.sv
// Randomized self-checking bench for locked_adder_key_tester: a 4-pattern
// instance checked every cycle against a run-level model, plus a 256-pattern instance.
module tb_locked_adder_key_tester;

    localparam logic [31:0] SEED        = 32'h0000_0001;
    localparam logic [31:0] TAPS        = 32'h8020_0003;
    localparam logic [31:0] CORRECT_KEY = 32'h1234_ABCD;
    localparam int          N4          = 4;
    localparam int          NF          = 256;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-pattern instance
    logic        start = 1'b0, ready = 1'b0;
    logic [31:0] key_in = 32'd0, key_out, ff;
    logic [15:0] add1, add2;
    logic [16:0] lres;
    logic        busy, valid, pass;
    logic [2:0]  err;
    logic [6:0]  bf;
    int          mode4 = 0;

    // 256-pattern instance
    logic        fstart = 1'b0, fready = 1'b1;
    logic [31:0] fkey_in = 32'd0, fkey_out, fff;
    logic [15:0] fadd1, fadd2;
    logic [16:0] flres;
    logic        fbusy, fvalid, fpass;
    logic [8:0]  ferr;
    logic [12:0] fbf;
    int          fmode = 3;

    // Bench-side stand-ins for the locked adder.
    // mode 0 ideal, 1 flips bit 0, 2 flips all bits on even add2, 3 key-locked adder.
    function automatic logic [16:0] stub(input int mode, input logic [31:0] k,
                                         input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s, c;
        logic [31:0] d;
        s = {1'b0, a} + {1'b0, b};
        d = k ^ CORRECT_KEY;
        case (mode)
            0:       c = 17'd0;
            1:       c = 17'h00001;
            2:       c = b[0] ? 17'd0 : 17'h1FFFF;
            default: c = (d[16:0] | {2'b00, d[31:17]}) & {a[0], b};
        endcase
        return s ^ c;
    endfunction

    assign lres  = stub(mode4, key_out, add1, add2);
    assign flres = stub(fmode, fkey_out, fadd1, fadd2);

    locked_adder_key_tester #(.NUM_PATTERNS(N4), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start_i(start), .key_i(key_in), .key_o(key_out),
        .add1_o(add1), .add2_o(add2), .locked_result_i(lres), .busy_o(busy),
        .res_valid_o(valid), .res_ready_i(ready), .err_count_o(err),
        .bitflip_o(bf), .first_fail_o(ff), .pass_o(pass));

    locked_adder_key_tester #(.NUM_PATTERNS(NF), .LFSR_SEED(SEED)) dut_full (
        .clk(clk), .rst(rst), .start_i(fstart), .key_i(fkey_in), .key_o(fkey_out),
        .add1_o(fadd1), .add2_o(fadd2), .locked_result_i(flres), .busy_o(fbusy),
        .res_valid_o(fvalid), .res_ready_i(fready), .err_count_o(ferr),
        .bitflip_o(fbf), .first_fail_o(fff), .pass_o(fpass));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    function automatic logic [31:0] pattern(input int j);
        logic [31:0] p;
        p = SEED;
        for (int i = 0; i < j; i++) p = lfsr_step(p);
        return p;
    endfunction

    // Whole-run expectation: walk the pattern list and score every response.
    function automatic void model_run(input int n, input logic [31:0] k, input int mode,
                                      output int e, output int b, output logic [31:0] f);
        logic [31:0] p;
        logic [16:0] d;
        e = 0; b = 0; f = 32'd0; p = SEED;
        for (int j = 0; j < n; j++) begin
            d = stub(mode, k, p[31:16], p[15:0]) ^ ({1'b0, p[31:16]} + {1'b0, p[15:0]});
            if (d != 17'd0) begin
                if (e == 0) f = p;
                e++;
            end
            b += $countones(d);
            p = lfsr_step(p);
        end
    endfunction

    // Transaction-level model of the 4-pattern instance, stepped on each edge.
    int          m_phase = 0;   // 0 idle, 1 run, 2 report
    int          m_k = 0;
    bit          m_zero = 1'b1;
    logic [31:0] m_key = 32'd0, m_add = 32'd0, e_ff = 32'd0;
    int          e_err = 0, e_bf = 0;
    bit          chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_key = 32'd0; m_add = 32'd0; m_zero = 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_k = 0; m_key = key_in; m_add = SEED; m_zero = 1'b0;
                    model_run(N4, key_in, mode4, e_err, e_bf, e_ff);
                end
                1: begin
                    m_k++;
                    if (m_k == N4) m_phase = 2;
                    else m_add = pattern(m_k);
                end
                default: if (ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("res_valid", 64'(valid), 64'(m_phase == 2));
            chk("key_o", 64'(key_out), 64'(m_key));
            chk("operands", 64'({add1, add2}), 64'(m_add));
            if (m_phase == 2) begin
                chk("err_count", 64'(err), 64'(e_err));
                chk("bitflip", 64'(bf), 64'(e_bf));
                chk("first_fail", 64'(ff), 64'(e_ff));
                chk("pass", 64'(pass), 64'(e_err == 0));
            end else if (m_zero) begin
                chk("zero_err", 64'(err), 64'd0);
                chk("zero_bf", 64'(bf), 64'd0);
                chk("zero_ff", 64'(ff), 64'd0);
                chk("zero_pass", 64'(pass), 64'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Starts a run on the 4-pattern instance and returns once res_valid is seen
    // (or the budget expires); cyc is the cycle index in which it rose.
    task automatic go4(input logic [31:0] k, input int mode, input bit hold_start,
                       output int cyc);
        int n;
        mode4 = mode; key_in = k; start = 1'b1; ready = 1'b0;
        tick(1);
        start = hold_start;
        n = 0;
        while (!valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("valid_timeout", 64'(valid), 64'd1);
        cyc = n + 1;
    endtask

    task automatic release4(input int delay);
        tick(delay);
        ready = 1'b1;
        tick(1);
        start = 1'b0; ready = 1'b0;
    endtask

    task automatic run_full(input logic [31:0] k, input bit expect_clean);
        int n, e, b;
        logic [31:0] f;
        fkey_in = k; fstart = 1'b1;
        tick(1);
        fstart = 1'b0;
        chk("full_busy", 64'(fbusy), 64'd1);
        n = 0;
        while (!fvalid && n < NF + 20) begin
            tick(1);
            n++;
        end
        chk("full_valid_cycle", 64'(n + 1), 64'(NF + 1));
        model_run(NF, k, 3, e, b, f);
        chk("full_err", 64'(ferr), 64'(e));
        chk("full_bf", 64'(fbf), 64'(b));
        chk("full_ff", 64'(fff), 64'(f));
        chk("full_pass", 64'(fpass), 64'(e == 0));
        chk("full_key", 64'(fkey_out), 64'(k));
        if (expect_clean) chk("full_clean", 64'(ferr), 64'd0);
        tick(1);
    endtask

    initial begin
        int cyc, e, b;
        logic [31:0] f, k;
        int mode, delay;
        bit hold, inject;

        // model pins: hand-computed LFSR steps and run scores
        chk("model_step1", 64'(pattern(1)), 64'h8020_0003);
        chk("model_step2", 64'(pattern(2)), 64'hC030_0002);
        chk("model_step3", 64'(pattern(3)), 64'h6018_0001);
        model_run(N4, 32'd0, 2, e, b, f);
        chk("model_even_err", 64'(e), 64'd1);
        chk("model_even_bf", 64'(b), 64'd17);
        chk("model_even_ff", 64'(f), 64'hC030_0002);

        tick(1);
        chk_on = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_key", 64'(key_out), 64'd0);
        chk("rst_ops", 64'({add1, add2}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        tick(2);

        // ideal adder: first pattern is the seed, result in cycle 5
        mode4 = 0; key_in = 32'hA5A5_5A5A; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("first_pattern", 64'({add1, add2}), 64'h0000_0001);
        tick(1);
        chk("second_pattern", 64'({add1, add2}), 64'h8020_0003);
        tick(3);
        chk("ideal_valid_c5", 64'(valid), 64'd1);
        chk("ideal_err", 64'(err), 64'd0);
        chk("ideal_bf", 64'(bf), 64'd0);
        chk("ideal_pass", 64'(pass), 64'd1);
        chk("ideal_ff", 64'(ff), 64'd0);
        chk("ideal_key", 64'(key_out), 64'hA5A5_5A5A);
        release4(0);

        // bit-0 inverter
        go4(32'h0, 1, 1'b0, cyc);
        chk("inv0_cycle", 64'(cyc), 64'd5);
        chk("inv0_err", 64'(err), 64'd4);
        chk("inv0_bf", 64'(bf), 64'd4);
        chk("inv0_pass", 64'(pass), 64'd0);
        chk("inv0_ff", 64'(ff), 64'h0000_0001);
        release4(0);

        // even-add2 inverter, with backpressure and start pulses during RUN/REPORT
        go4(32'h0, 2, 1'b1, cyc);
        chk("even_bf_ratio", 64'(bf), 64'(17 * err));
        chk("even_ff", 64'(ff), 64'hC030_0002);
        release4(10);
        go4(32'h0, 2, 1'b0, cyc);
        chk("rearm_err", 64'(err), 64'd1);
        release4(0);

        // reset while pattern 2 is on the operands
        mode4 = 0; key_in = 32'h5555_AAAA; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("pre_rst_ops", 64'({add1, add2}), 64'hC030_0002);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_valid", 64'(valid), 64'd0);
        chk("midrun_rst_key", 64'(key_out), 64'd0);
        go4(32'h5555_AAAA, 1, 1'b0, cyc);
        chk("post_rst_err", 64'(err), 64'd4);
        release4(1);

        // randomized runs, some cut short by reset
        for (int it = 0; it < 40; it++) begin
            k = $urandom;
            mode = $urandom_range(0, 3);
            delay = $urandom_range(0, 12);
            hold = 1'($urandom_range(0, 1));
            inject = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) k = CORRECT_KEY ^ (32'd1 << $urandom_range(0, 31));
            if (inject) begin
                mode4 = mode; key_in = k; start = 1'b1;
                tick(1);
                start = hold;
                tick($urandom_range(0, 5));
                rst = 1'b1; start = 1'b0;
                tick(1);
                rst = 1'b0;
                tick($urandom_range(0, 2));
            end else begin
                go4(k, mode, hold, cyc);
                release4(delay);
                tick($urandom_range(0, 2));
            end
        end

        // full-length runs with the key-locked adder
        run_full(CORRECT_KEY, 1'b1);
        run_full(CORRECT_KEY ^ 32'h0000_0008, 1'b0);
        run_full(CORRECT_KEY ^ (32'd1 << $urandom_range(0, 31)), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
